serializer_ddr_gen: RTL
=======================

# serializer_ddr_gen

Parametrised DDR output serializer for GateMate, the next generation of the fixed 10:1 design. It accepts parallel words for `LANES` independent lanes through a valid/ready handshake and shifts out two bits per `fast_clk_i` cycle through one `CC_ODDR` per lane. Everything runs in the single fast domain; the upstream packer, e.g. a TMDS encoder behind a CDC FIFO, supplies words at up to one per `WIDTH/2` cycles. It sits directly in front of the I/O pads.

## Interface
- `WIDTH`, 10: bits per word per lane; even, ≥4.
- `LANES`, 1: number of lanes; all lanes share the handshake and are beat-aligned.
- `MSB_FIRST`, 0: 0 sends bit 0 first; 1 sends bit `WIDTH-1` first.
- `INVERT`, 1: 1 inverts data into `CC_ODDR`, compensating inverting pad wiring.
- `IDLE_WORD`, `WIDTH'h0`: word sent on underrun (used only when `SERIALIZER_IDLE_EN` is defined).
- `fast_clk_i`, in, 1: the single clock, also drives the `CC_ODDR` clock and DDR inputs.
- `rst`, in, 1: synchronous, active-high reset.
- `dat_i`, in, `LANES*WIDTH`: lane *k* occupies bits `[k*WIDTH +: WIDTH]`.
- `valid_i`, in, 1: a word is present on `dat_i`.
- `ready_o`, out, 1: the holding register is empty; a transfer occurs when `valid_i && ready_o`.
- `dat_o`, out, `LANES`: serial DDR output per lane.
- `word_start_o`, out, 1: one-cycle pulse when the first bit pair of a word is presented to the ODDRs.
- `underrun_o`, out, 1: one-cycle pulse when a word boundary finds the holding register empty.

## Operation
- `BEATS = WIDTH/2` cycles per word.
- Datapath per lane:
  - one holding register, `hold`, with a flag `hold_full`;
  - one shift register, `shreg`;
  - a shared beat counter `beat` running from 0 to `BEATS-1`.
- `ready_o = !hold_full`. On a transfer, `hold` captures `dat_i` and `hold_full` is set.
- States:
  - `IDLE`: no word loaded; ODDR inputs are constant 0 (before `INVERT`).
  - `RUN`: shifting.
- `IDLE`→`RUN`: the cycle after `hold_full` is seen. Load `shreg` from `hold`, clear `hold_full`, set `beat` to 0, pulse `word_start_o`.
- In `RUN`, each cycle presents one pair (first bit, second bit), then shifts `shreg` by 2 toward the sent end.
- At `beat == BEATS-1`:
  - if `hold_full` is set, or a transfer is occurring this same cycle with the bypass-free rule below, reload from `hold` with no gap and pulse `word_start_o`;
  - else, without the macro, go to `IDLE` and pulse `underrun_o`; with the macro, see Configuration.
- Bypass-free rule: a word written into `hold` is loaded no earlier than the following cycle. A transfer at the final beat therefore produces one underrun.
- Simultaneous load and transfer: clearing `hold_full` and setting it in the same cycle leaves it set. `ready_o` drops in the next cycle only if no load follows.
- Bit order:
  - pair *j* is bits (2j, 2j+1) when `MSB_FIRST=0`;
  - pair *j* is bits (`WIDTH-1-2j`, `WIDTH-2-2j`) when `MSB_FIRST=1`;
  - the first bit of each pair goes to the ODDR half launched first in the cycle (`D0`).
- Reset:
  - `hold_full=0`, `ready_o=0` while `rst` is high and 1 from the first cycle after;
  - state `IDLE`, `beat=0`, `word_start_o=0`, `underrun_o=0`;
  - ODDR inputs are 0 (before `INVERT`);
  - reset mid-word abandons the word immediately, and the held word is discarded.

## Timing
- Transfer at cycle N with `IDLE` and the holding register empty: `hold` is written at N+1, `shreg` loads and `word_start_o` pulses at N+2, and the first pair reaches the ODDR inputs at N+2.
- Pin delay adds the `CC_ODDR` latency of one `fast_clk_i` cycle.
- Sustained throughput is one word per `BEATS` cycles. `valid_i` may be held high continuously.
- `ready_o` and both pulses are registered; no combinational path runs from `valid_i` to `ready_o`.

## Configuration
- `SERIALIZER_IDLE_EN` defined: an underrun at a word boundary loads `IDLE_WORD` into every lane's `shreg`, stays in `RUN` and pulses `underrun_o`. `word_start_o` still pulses, keeping the line framed. `IDLE` is left at the first word after reset and never re-entered except by reset.
- Not defined: the behaviour above, where an underrun drops to `IDLE` with constant-0 output.

## Structure
- Package `serializer_pkg`:
  - state enum (`IDLE`, `RUN`);
  - function `beats(width)`;
  - function `pair_sel(word, j, msb_first)` returning the 2-bit pair.
- Sub-module `serializer_lane`: holds one lane's `hold`/`shreg` and its `CC_ODDR`. The top holds the FSM, the beat counter and the handshake, and generates `LANES` instances.

## Test plan
- Reset release, no `valid_i` → `ready_o` rises one cycle after `rst` falls; `dat_o` stays at the inverted-0 level; no pulses.
- `WIDTH=10`, `MSB_FIRST=0`, `INVERT=0`, one word `10'b1100110101` → ODDR pairs (1,0),(1,0),(1,1),(0,0),(1,1); `word_start_o` at N+2; `underrun_o` at the last beat.
- Same word with `MSB_FIRST=1` → pairs (1,1),(0,0),(1,1),(0,1),(0,1).
- `LANES=3`, `valid_i` held high for 8 words → no gaps; `word_start_o` every 5 cycles; no `underrun_o`; each lane carries its own slice.
- Transfer exactly at `beat==4` after an idle hold → one `underrun_o`, then the word starts at the next cycle.
- `rst` asserted at beat 2 with `hold_full=1` → next cycle: `IDLE`, ODDR inputs 0, held word discarded; with `SERIALIZER_IDLE_EN`, underruns send `IDLE_WORD=10'h3FF` as all-ones pairs.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and helpers for the DDR output serializer.
// State enum, beats-per-word helper and the bit-pair selector that fixes
// the on-wire bit order.
package serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest word the pair selector accepts.
  localparam int MAX_WIDTH = 64;

  // Cycles needed to send one word at two bits per cycle.
  function automatic int beats(input int width);
    return width / 2;
  endfunction

  // Returns pair j of a word: bit [0] is sent first (D0), bit [1] second (D1).
  function automatic logic [1:0] pair_sel(input logic [MAX_WIDTH-1:0] word,
                                          input int                   j,
                                          input logic                 msb_first,
                                          input int                   width);
    logic [5:0] idx_first;
    logic [5:0] idx_second;
    if (msb_first) begin
      idx_first  = 6'(width - 1 - 2 * j);
      idx_second = 6'(width - 2 - 2 * j);
    end else begin
      idx_first  = 6'(2 * j);
      idx_second = 6'(2 * j + 1);
    end
    return {word[idx_second], word[idx_first]};
  endfunction

endpackage

// File: rtl/serializer_cc_oddr.sv
// CC_ODDR: behavioural stand-in for the GateMate DDR output cell, used for
// simulation and lint only. Leave this file out of the GateMate build, where
// the vendor cell library supplies the real primitive.
// D0 is launched in the high phase of DDR, D1 in the low phase.
module CC_ODDR (
  input  logic DDR,
  input  logic CLK,
  input  logic D0,
  input  logic D1,
  output logic Q
);

  logic d0_q;
  logic d1_q;

  // Capture both halves of the pair on the rising clock edge
  always_ff @(posedge CLK) begin
    d0_q <= D0;
    d1_q <= D1;
  end

  assign Q = DDR ? d0_q : d1_q;

endmodule

// File: rtl/serializer_ddr_gen_lane.sv
// serializer_lane: one lane of the DDR serializer. Holds the lane's holding
// register and shift register and drives one CC_ODDR. The shift register is
// loaded already in send order so the outgoing pair is always bits [1:0].
module serializer_lane
  import serializer_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter bit               MSB_FIRST = 1'b0,
  parameter bit               INVERT    = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             load_i,
  input  logic             idle_load_i,
  input  logic             run_i,
  output logic             dat_o
);

  localparam int BEATS = beats(WIDTH);

  logic [WIDTH-1:0]     hold_q;
  logic [WIDTH-1:0]     hold_d;
  logic [WIDTH-1:0]     shreg_q;
  logic [WIDTH-1:0]     shreg_d;
  logic [MAX_WIDTH-1:0] src_s;
  logic [WIDTH-1:0]     ordered_s;
  logic                 d0_s;
  logic                 d1_s;

  // Reorder the word being loaded so pair j sits in bits [2j+1:2j]
  always_comb begin
    src_s = '0;
    if (idle_load_i) begin
      src_s[WIDTH-1:0] = IDLE_WORD;
    end else begin
      src_s[WIDTH-1:0] = hold_q;
    end
    ordered_s = '0;
    for (int j = 0; j < BEATS; j++) begin
      ordered_s[2*j +: 2] = pair_sel(src_s, j, MSB_FIRST, WIDTH);
    end
  end

  // Holding register capture and shift register load/shift
  always_comb begin
    if (cap_i) begin
      hold_d = dat_i;
    end else begin
      hold_d = hold_q;
    end
    if (load_i || idle_load_i) begin
      shreg_d = ordered_s;
    end else begin
      shreg_d = {2'b00, shreg_q[WIDTH-1:2]};
    end
  end

  // Lane registers; reset discards both the held and the in-flight word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q  <= '0;
      shreg_q <= '0;
    end else begin
      hold_q  <= hold_d;
      shreg_q <= shreg_d;
    end
  end

  // Outside RUN the pad sees a constant 0 before the optional inversion.
  assign d0_s = (run_i & shreg_q[0]) ^ INVERT;
  assign d1_s = (run_i & shreg_q[1]) ^ INVERT;

  CC_ODDR oddr_u (
    .DDR (clk_i),
    .CLK (clk_i),
    .D0  (d0_s),
    .D1  (d1_s),
    .Q   (dat_o)
  );

endmodule

// File: rtl/serializer_ddr_gen.sv
// serializer_ddr_gen: parametrised DDR output serializer for GateMate.
// Owns the IDLE/RUN FSM, the shared beat counter and the valid/ready
// handshake; LANES serializer_lane instances do the per-lane datapath.
// Optional feature macro: SERIALIZER_IDLE_EN (send IDLE_WORD on underrun
// instead of dropping to IDLE).
module serializer_ddr_gen
  import serializer_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter int               LANES     = 1,
  parameter bit               MSB_FIRST = 1'b0,
  parameter bit               INVERT    = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                   fast_clk_i,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] dat_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [LANES-1:0]       dat_o,
  output logic                   word_start_o,
  output logic                   underrun_o
);

  localparam int BEATS = beats(WIDTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e        state_q;
  state_e        state_d;
  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;
  logic          hold_full_q;
  logic          hold_full_d;
  logic          ready_q;
  logic          ready_d;
  logic          ws_q;
  logic          ws_d;
  logic          ur_q;
  logic          ur_d;
  logic          xfer_s;
  logic          load_s;
  logic          idle_load_s;
  logic          last_s;
  logic          run_s;

  // ready_q mirrors !hold_full, so the transfer never looks at valid_i twice.
  assign xfer_s = valid_i & ready_q;
  assign last_s = (beat_q == BW'(BEATS - 1));
  assign run_s  = (state_q == RUN);

  // Next state, beat counter, shift-register loads and pulse requests
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    load_s      = 1'b0;
    idle_load_s = 1'b0;
    ws_d        = 1'b0;
    ur_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = RUN;
          beat_d  = '0;
          load_s  = 1'b1;
          ws_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!last_s) begin
          beat_d = beat_q + BW'(1);
        end else if (hold_full_q) begin
          beat_d = '0;
          load_s = 1'b1;
          ws_d   = 1'b1;
        end else begin
`ifdef SERIALIZER_IDLE_EN
          // Keep the line framed: send the idle word as a full word.
          beat_d      = '0;
          idle_load_s = 1'b1;
          ws_d        = 1'b1;
          ur_d        = 1'b1;
`else
          state_d = IDLE;
          beat_d  = '0;
          ur_d    = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Holding flag: a same-cycle load and transfer leaves it set
  always_comb begin
    hold_full_d = xfer_s | (hold_full_q & ~load_s);
    ready_d     = ~hold_full_d;
  end

  // Control registers with synchronous reset
  always_ff @(posedge fast_clk_i) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      ws_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      ws_q        <= ws_d;
      ur_q        <= ur_d;
    end
  end

  assign ready_o      = ready_q;
  assign word_start_o = ws_q;
  assign underrun_o   = ur_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    serializer_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .INVERT    (INVERT),
      .IDLE_WORD (IDLE_WORD)
    ) lane_u (
      .clk_i       (fast_clk_i),
      .rst_i       (rst),
      .cap_i       (xfer_s),
      .dat_i       (dat_i[k*WIDTH +: WIDTH]),
      .load_i      (load_s),
      .idle_load_i (idle_load_s),
      .run_i       (run_s),
      .dat_o       (dat_o[k])
    );
  end

endmodule
